alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter feeding a shared ALU through an issue stage,
// with a registered response stage and an architectural status register.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req_val_1,
    input  logic [63:0] req_val_2,
    input  logic [7:0]  req_exe_cmd,
    input  logic [1:0]  req_s,
    output logic [1:0]  gnt,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] alu_val_1,
    output logic [31:0] alu_val_2,
    output logic [3:0]  alu_exe_cmd,
    output logic [3:0]  alu_sr_in,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_sr,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_sr,
    output logic [3:0]  status
);
    logic        prio;
    logic        iss_valid;
    logic        iss_id;
    logic        iss_s;
    logic [31:0] iss_val_1;
    logic [31:0] iss_val_2;
    logic [3:0]  iss_cmd;
    logic        gid;
    logic        fire;

    always_comb begin
        gnt  = (rst || stall || flush) ? 2'b00 : (&req_valid) ? (prio ? 2'b10 : 2'b01) : req_valid;
        gid  = gnt[1];
        fire = iss_valid && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= 1'b0;
            iss_valid <= 1'b0;
            iss_id    <= 1'b0;
            iss_s     <= 1'b0;
            iss_val_1 <= 32'd0;
            iss_val_2 <= 32'd0;
            iss_cmd   <= 4'd0;
        end else begin
            iss_valid <= |gnt;
            if (|gnt) begin
                prio      <= ~gid;
                iss_id    <= gid;
                iss_s     <= req_s[gid];
                iss_val_1 <= gid ? req_val_1[63:32] : req_val_1[31:0];
                iss_val_2 <= gid ? req_val_2[63:32] : req_val_2[31:0];
                iss_cmd   <= gid ? req_exe_cmd[7:4] : req_exe_cmd[3:0];
            end
        end
    end

    // A flushed op never reaches the response stage or touches status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_sr     <= 4'd0;
            status     <= 4'd0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_id     <= iss_id;
                rsp_result <= alu_result;
                rsp_sr     <= alu_sr;
                if (iss_s)
                    status <= alu_sr;
            end
        end
    end

    assign alu_val_1   = iss_val_1;
    assign alu_val_2   = iss_val_2;
    assign alu_exe_cmd = iss_cmd;
    assign alu_sr_in   = status;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_val_1;
    logic [63:0] req_val_2;
    logic [7:0]  req_exe_cmd;
    logic [1:0]  req_s;
    logic [1:0]  gnt;
    logic        stall;
    logic        flush;
    logic [31:0] alu_val_1;
    logic [31:0] alu_val_2;
    logic [3:0]  alu_exe_cmd;
    logic [3:0]  alu_sr_in;
    logic [31:0] alu_result;
    logic [3:0]  alu_sr;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_sr;
    logic [3:0]  status;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_val_1(req_val_1),
        .req_val_2(req_val_2), .req_exe_cmd(req_exe_cmd), .req_s(req_s), .gnt(gnt),
        .stall(stall), .flush(flush), .alu_val_1(alu_val_1), .alu_val_2(alu_val_2),
        .alu_exe_cmd(alu_exe_cmd), .alu_sr_in(alu_sr_in), .alu_result(alu_result),
        .alu_sr(alu_sr), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_sr(rsp_sr), .status(status)
    );

    // ALU: 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC (carry = borrow), 0001 OR, else AND
    logic [32:0] w;
    logic        ov;
    always_comb begin
        w  = {1'b0, alu_val_1 & alu_val_2};
        ov = 1'b0;
        case (alu_exe_cmd)
            4'b0001: w = {1'b0, alu_val_1 | alu_val_2};
            4'b0010: w = {1'b0, alu_val_1} + {1'b0, alu_val_2};
            4'b0011: w = {1'b0, alu_val_1} + {1'b0, alu_val_2} + {32'd0, alu_sr_in[2]};
            4'b0100: w = {1'b0, alu_val_1} - {1'b0, alu_val_2};
            4'b0101: w = {1'b0, alu_val_1} - {1'b0, alu_val_2} - {32'd0, alu_sr_in[2]};
            default: ;
        endcase
        if (alu_exe_cmd == 4'b0010 || alu_exe_cmd == 4'b0011)
            ov = (alu_val_1[31] == alu_val_2[31]) && (w[31] != alu_val_1[31]);
        if (alu_exe_cmd == 4'b0100 || alu_exe_cmd == 4'b0101)
            ov = (alu_val_1[31] != alu_val_2[31]) && (w[31] != alu_val_1[31]);
        alu_result = w[31:0];
        alu_sr     = {w[31:0] == 32'd0, w[32], w[31], ov};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic s);
        req_val_1[k*32 +: 32] = a;
        req_val_2[k*32 +: 32] = b;
        req_exe_cmd[k*4 +: 4] = c;
        req_s[k]              = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_val_1 = '0; req_val_2 = '0;
        req_exe_cmd = '0; req_s = '0; stall = 1'b0; flush = 1'b0;
        #1;
        check("gnt_in_reset", {30'd0, gnt}, 32'd0);
        tick();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_status", {28'd0, status}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_alu_val_1", alu_val_1, 32'd0);
        rst = 1'b0;

        // round robin with both requesting
        set_op(0, 32'd1, 32'd1, 4'b0010, 1'b0);
        set_op(1, 32'd2, 32'd2, 4'b0010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4) ? 2'b11 : 2'b00;
            #1;
            if (i < 4) check($sformatf("rr_gnt%0d", i), {30'd0, gnt}, (i % 2) ? 32'd2 : 32'd1);
            if (i >= 2) begin
                check($sformatf("rr_rsp_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
                check($sformatf("rr_rsp_id%0d", i), {31'd0, rsp_id}, i % 2);
                check($sformatf("rr_rsp_result%0d", i), rsp_result, (i % 2) ? 32'd4 : 32'd2);
            end
            tick();
        end
        check("rr_rsp_idle", {31'd0, rsp_valid}, 32'd0);
        check("rr_status", {28'd0, status}, 32'd0);

        // signed overflow ADD with status update
        set_op(0, 32'h7FFF_FFFF, 32'h1, 4'b0010, 1'b1);
        req_valid = 2'b01;
        #1 check("ovf_gnt", {30'd0, gnt}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("ovf_alu_val_1", alu_val_1, 32'h7FFF_FFFF);
        check("ovf_alu_cmd", {28'd0, alu_exe_cmd}, 32'd2);
        check("ovf_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("ovf_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("ovf_rsp_result", rsp_result, 32'h8000_0000);
        check("ovf_rsp_sr", {28'd0, rsp_sr}, 32'b0011);
        check("ovf_status", {28'd0, status}, 32'b0011);
        check("ovf_alu_sr_in", {28'd0, alu_sr_in}, 32'b0011);

        // SUB with s=0 leaves status alone
        set_op(1, 32'd5, 32'd5, 4'b0100, 1'b0);
        req_valid = 2'b10;
        #1 check("sub_gnt", {30'd0, gnt}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check("sub_rsp_id", {31'd0, rsp_id}, 32'd1);
        check("sub_rsp_result", rsp_result, 32'd0);
        check("sub_rsp_sr", {28'd0, rsp_sr}, 32'b1000);
        check("sub_status", {28'd0, status}, 32'b0011);

        // back-to-back ADD then ADC consuming the fresh carry
        set_op(0, 32'hFFFF_FFFF, 32'h1, 4'b0010, 1'b1);
        req_valid = 2'b01;
        #1 check("fwd_gnt0", {30'd0, gnt}, 32'd1);
        tick();
        set_op(0, 32'd0, 32'd0, 4'b0011, 1'b0);
        #1 check("fwd_gnt1", {30'd0, gnt}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("fwd_rsp0_result", rsp_result, 32'd0);
        check("fwd_rsp0_sr", {28'd0, rsp_sr}, 32'b1100);
        check("fwd_status0", {28'd0, status}, 32'b1100);
        tick();
        check("fwd_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        check("fwd_rsp1_result", rsp_result, 32'd1);
        check("fwd_rsp1_sr", {28'd0, rsp_sr}, 32'b0000);
        check("fwd_status1", {28'd0, status}, 32'b1100);
        tick();
        check("fwd_idle", {31'd0, rsp_valid}, 32'd0);

        // stall blocks grants but not the op in issue
        set_op(0, 32'd1, 32'd1, 4'b0010, 1'b0);
        req_valid = 2'b01;
        tick();
        stall = 1'b1; req_valid = 2'b11;
        #1 check("stall_gnt", {30'd0, gnt}, 32'd0);
        tick();
        stall = 1'b0; req_valid = 2'b00;
        check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_rsp_result", rsp_result, 32'd2);
        tick();
        check("stall_no_extra", {31'd0, rsp_valid}, 32'd0);

        // flush discards the issued op
        set_op(0, 32'd3, 32'd4, 4'b0010, 1'b1);
        set_op(1, 32'd10, 32'd20, 4'b0010, 1'b1);
        req_valid = 2'b01;
        #1 check("fl_gnt0", {30'd0, gnt}, 32'd1);
        tick();
        flush = 1'b1; req_valid = 2'b10;
        #1 check("fl_gnt_flush", {30'd0, gnt}, 32'd0);
        tick();
        flush = 1'b0;
        #1 check("fl_gnt_r1", {30'd0, gnt}, 32'd2);
        check("fl_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("fl_status", {28'd0, status}, 32'b1100);
        tick();
        req_valid = 2'b00;
        check("fl_no_rsp2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("fl_r1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("fl_r1_rsp_id", {31'd0, rsp_id}, 32'd1);
        check("fl_r1_rsp_result", rsp_result, 32'd30);
        check("fl_r1_status", {28'd0, status}, 32'b0000);

        // reset while an op sits in issue
        set_op(0, 32'd5, 32'd6, 4'b0010, 1'b1);
        req_valid = 2'b01;
        tick();
        rst = 1'b1;
        #1;
        check("mr_gnt", {30'd0, gnt}, 32'd0);
        check("mr_rsp_result", rsp_result, 32'd0);
        check("mr_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("mr_alu_val_1", alu_val_1, 32'd0);
        check("mr_alu_cmd", {28'd0, alu_exe_cmd}, 32'd0);
        tick();
        rst = 1'b0; req_valid = 2'b00;
        tick();
        check("mr_no_rsp0", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("mr_no_rsp1", {31'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        #1 check("mr_prio_r0", {30'd0, gnt}, 32'd1);
        tick();
        req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
